// File: rtl/if_fetch.sv
// Instruction fetch: four pipelined byte reads, assembled little-endian into one output register.
// Word reaches is_o 5 cycles after its first read; stall_i holds the output and fetch parks on a buffered word.
module if_fetch #(
    parameter logic [31:0] RST_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    input  logic        mem_busy,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_a,
    output logic [31:0] pc_o,
    output logic [31:0] is_o,
    output logic [31:0] ppc_o
);
    logic [31:0] fpc_q, fpc_d;
    logic [2:0]  icnt_q, icnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        full_q, full_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] is_q, is_d;
    logic [31:0] ppc_q, ppc_d;

    logic        last_byte;
    logic        word_rdy;
    logic        slot_free;
    logic [31:0] word;

    always_comb begin
        mem_req   = (icnt_q < 3'd4) && !full_q && !mem_busy && !br_e && !rst;
        mem_a     = mem_req ? (fpc_q + {29'd0, icnt_q}) : 32'h0;

        fpc_d     = fpc_q;
        icnt_d    = mem_req ? (icnt_q + 3'd1) : icnt_q;
        pend_d    = mem_req;
        pidx_d    = icnt_q[1:0];
        wbuf_d    = wbuf_q;
        full_d    = full_q;
        pc_d      = pc_q;
        is_d      = is_q;
        ppc_d     = ppc_q;

        // A byte in flight is always captured; mem_busy only gates new issues.
        if (pend_q) begin
            wbuf_d[{pidx_q, 3'b000} +: 8] = mem_din;
        end

        // The final byte bypasses the buffer so a free slot sees the word without an extra cycle.
        last_byte = pend_q && (pidx_q == 2'd3);
        word_rdy  = full_q || last_byte;
        word      = full_q ? wbuf_q : {mem_din, wbuf_q[23:0]};
        slot_free = (is_q == 32'h0) || !stall_i;

        if (word_rdy && slot_free) begin
            pc_d   = fpc_q;
            is_d   = word;
            ppc_d  = fpc_q + 32'd4;
            fpc_d  = fpc_q + 32'd4;
            icnt_d = 3'd0;
            full_d = 1'b0;
        end else begin
            if (last_byte) begin
                full_d = 1'b1;
            end
            if (!stall_i) begin
                pc_d  = 32'h0;
                is_d  = 32'h0;
                ppc_d = 32'h0;
            end
        end

        // Redirect squashes the wrong-path word even under stall.
        if (br_e) begin
            fpc_d  = br_addr;
            icnt_d = 3'd0;
            pend_d = 1'b0;
            full_d = 1'b0;
            wbuf_d = 32'h0;
            pc_d   = 32'h0;
            is_d   = 32'h0;
            ppc_d  = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q  <= RST_PC;
            icnt_q <= 3'd0;
            pend_q <= 1'b0;
            pidx_q <= 2'd0;
            wbuf_q <= 32'h0;
            full_q <= 1'b0;
            pc_q   <= 32'h0;
            is_q   <= 32'h0;
            ppc_q  <= 32'h0;
        end else begin
            fpc_q  <= fpc_d;
            icnt_q <= icnt_d;
            pend_q <= pend_d;
            pidx_q <= pidx_d;
            wbuf_q <= wbuf_d;
            full_q <= full_d;
            pc_q   <= pc_d;
            is_q   <= is_d;
            ppc_q  <= ppc_d;
        end
    end

    assign pc_o  = pc_q;
    assign is_o  = is_q;
    assign ppc_o = ppc_q;
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte-wide memory model plus queue of expected presented words.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_e = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        mem_busy = 1'b0;
    logic [7:0]  mem_din = 8'h0;
    logic        mem_req;
    logic [31:0] mem_a;
    logic [31:0] pc_o;
    logic [31:0] is_o;
    logic [31:0] ppc_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] is;
        logic [31:0] ppc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    if_fetch #(.RST_PC(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall_i),
        .br_e     (br_e),
        .br_addr  (br_addr),
        .mem_busy (mem_busy),
        .mem_din  (mem_din),
        .mem_req  (mem_req),
        .mem_a    (mem_a),
        .pc_o     (pc_o),
        .is_o     (is_o),
        .ppc_o    (ppc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'hA0;
            32'd3:   return 8'h00;
            default: return 8'h80 | (a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]);
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory answers the address issued in the previous cycle.
    always @(posedge clk) begin
        mem_din <= mem_req ? mem_byte(mem_a) : 8'hEE;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h %h %h want 0 0 0", pc_o, is_o, ppc_o);
        end
        n_checks++;
        if ({mem_req, mem_a} !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b a=%h want 0 0", mem_req, mem_a);
        end
    endtask

    task automatic test_first_fetch;
        sb.push_back({32'h0, 32'h00A00513, 32'h4});
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'(c)}) begin
                n_fail++;
                $display("FAIL first_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, c);
            end
            tick();
        end
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_idle: got req=%b want 0", mem_req);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL first_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
        n_checks++;
        if ({mem_req, mem_a} !== {1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL first_next: got req=%b a=%h want 1 4", mem_req, mem_a);
        end
    endtask

    task automatic test_mem_busy;
        sb.push_back({32'h4, exp_word(32'h4), 32'h8});
        tick();
        mem_busy = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, is_o} !== 33'h0) begin
            n_fail++;
            $display("FAIL busy_c1: got req=%b is=%h want 0 0", mem_req, is_o);
        end
        tick();
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_c2: got req=%b want 0", mem_req);
        end
        tick();
        mem_busy = 1'b0;
        #1;
        for (int c = 1; c < 4; c++) begin
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'h4 + 32'(c)}) begin
                n_fail++;
                $display("FAIL busy_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, 4 + c);
            end
            tick();
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL busy_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
    endtask

    task automatic test_stall;
        stall_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if ({pc_o, is_o} !== {32'h4, exp_word(32'h4)}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc=%h is=%h want 4 %h", k, pc_o, is_o, exp_word(32'h4));
            end
            if (k >= 3) begin
                n_checks++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_park%0d: got req=%b want 0", k, mem_req);
                end
            end
        end
        sb.push_back({32'h8, exp_word(32'h8), 32'hC});
        stall_i = 1'b0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL stall_release: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
        n_checks++;
        if ({mem_req, mem_a} !== {1'b1, 32'hC}) begin
            n_fail++;
            $display("FAIL stall_next: got req=%b a=%h want 1 c", mem_req, mem_a);
        end
    endtask

    task automatic test_redirect;
        stall_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_req, mem_a, is_o} !== {1'b1, 32'hE, exp_word(32'h8)}) begin
            n_fail++;
            $display("FAIL br_pre: got req=%b a=%h is=%h want 1 e %h", mem_req, mem_a, is_o, exp_word(32'h8));
        end
        br_e = 1'b1;
        br_addr = 32'h1000;
        sb.push_back({32'h1000, exp_word(32'h1000), 32'h1004});
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL br_noreq: got req=%b want 0", mem_req);
        end
        tick();
        br_e = 1'b0;
        #1;
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== 96'h0) begin
            n_fail++;
            $display("FAIL br_squash: got %h %h %h want 0 0 0", pc_o, is_o, ppc_o);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'h1000 + 32'(c)}) begin
                n_fail++;
                $display("FAIL br_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, 32'h1000 + c);
            end
            tick();
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL br_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
        stall_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        tick();
        tick();
        tick();
        n_checks++;
        if ({mem_req, mem_a} !== {1'b1, 32'h1007}) begin
            n_fail++;
            $display("FAIL rst_pre: got req=%b a=%h want 1 1007", mem_req, mem_a);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({pc_o, is_o, ppc_o, mem_req, mem_a} !== 129'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got %h %h %h req=%b a=%h want all 0", pc_o, is_o, ppc_o, mem_req, mem_a);
        end
        rst = 1'b0;
        sb.push_back({32'h0, 32'h00A00513, 32'h4});
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'(c)}) begin
                n_fail++;
                $display("FAIL rst_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, c);
            end
            tick();
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL rst_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
    endtask

    task automatic test_wrap;
        br_e = 1'b1;
        br_addr = 32'hFFFF_FFFC;
        sb.push_back({32'hFFFF_FFFC, exp_word(32'hFFFF_FFFC), 32'h0});
        tick();
        br_e = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'hFFFF_FFFC + 32'(c)}) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, 32'hFFFF_FFFC + c);
            end
            tick();
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL wrap_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
        n_checks++;
        if ({mem_req, mem_a} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_next: got req=%b a=%h want 1 0", mem_req, mem_a);
        end
    endtask

    task automatic test_back_to_back;
        sb.push_back({32'h0, 32'h00A00513, 32'h4});
        for (int c = 1; c < 4; c++) begin
            tick();
            n_checks++;
            if ({mem_req, mem_a} !== {1'b1, 32'(c)}) begin
                n_fail++;
                $display("FAIL b2b_addr%0d: got req=%b a=%h want 1 %h", c, mem_req, mem_a, c);
            end
        end
        tick();
        n_checks++;
        if ({mem_req, is_o} !== 33'h0) begin
            n_fail++;
            $display("FAIL b2b_bubble: got req=%b is=%h want 0 0", mem_req, is_o);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({pc_o, is_o, ppc_o} !== e) begin
            n_fail++;
            $display("FAIL b2b_word: got %h %h %h want %h %h %h", pc_o, is_o, ppc_o, e.pc, e.is, e.ppc);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_mem_busy();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline; feeds the decode stage's `pc`/`is`/`ppc_i` inputs.
- Fetches each 32-bit instruction from an 8-bit-wide unified memory port as four byte reads, pipelined one byte per cycle.
- Assembles the bytes little-endian and presents the word to decode through a single output register.
- Accepts pipeline stalls and a branch/jump redirect from execute.

Parameters:
- RST_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  decode cannot accept; hold output register
- br_e  in  1  redirect strobe from execute (one cycle)
- br_addr  in  32  redirect target
- mem_busy  in  1  memory port granted to load/store unit this cycle
- mem_din  in  8  read data for the address issued the previous cycle
- mem_req  out  1  fetch issues a read this cycle
- mem_a  out  32  byte address of the read
- pc_o  out  32  PC of presented instruction
- is_o  out  32  presented instruction; 32'h0 means bubble
- ppc_o  out  32  predicted next PC (pc_o + 4)

Behaviour:
- State:
  - fpc: PC of the word being fetched.
  - icnt (0..4): next byte index to issue.
  - pend / pidx: a read was issued last cycle, and its byte index.
  - buf[31:0]: assembly buffer.
  - full: buf holds a complete word not yet presented.
  - Output register: pc_o, is_o, ppc_o.
- Reset (sync): fpc=RST_PC, icnt=0, pend=0, full=0, buf=0, pc_o=is_o=ppc_o=0, mem_req=0, mem_a=0.
- Issue (combinational):
  - mem_req=1 when icnt<4 && !full && !mem_busy && !br_e && !rst.
  - mem_a = fpc + icnt. When mem_req=0, mem_a=0.
  - Each cycle with mem_req=1: icnt++, pend<=1, pidx<=icnt. Otherwise pend<=0.
- Capture:
  - If pend, buf[8*pidx +: 8] <= mem_din, regardless of mem_busy.
  - mem_busy only blocks new issues. A byte already in flight is always captured.
- Completion: capturing pidx==3 sets full (word = {b3,b2,b1,b0}).
- Latency: with no busy or stall, first byte address at cycle 0, word in is_o at cycle 5, next word's first address at cycle 5. Throughput is one instruction per 5 cycles.
- Handoff:
  - The output slot is free when is_o==0 or stall_i==0.
  - If full and the slot is free: load pc_o=fpc, is_o=buf, ppc_o=fpc+4; set fpc<=fpc+4, icnt<=0, full<=0.
  - Else if stall_i==0: is_o<=0, pc_o<=0, ppc_o<=0 (decode consumed the word, bubble inserted).
  - Else if stall_i==1: output register holds.
- Redirect (br_e=1) has highest priority after rst:
  - fpc<=br_addr, icnt<=0, pend<=0, full<=0, buf<=0.
  - Output register cleared to 0 (wrong-path word squashed) even if stall_i=1.
  - No mem_req that cycle. Fetch from br_addr starts the next cycle.
- Unaligned br_addr is not checked; it is fetched as four consecutive bytes.
- fpc+icnt and fpc+4 wrap modulo 2^32.
- Reset mid-fetch: all state discarded, as in Reset. A read issued in the reset cycle's predecessor is ignored.
- Simultaneous br_e and stall_i: redirect wins. Simultaneous full and mem_busy: handoff proceeds, since it needs no memory.

Test Plan:
1. Reset, then memory bytes 0..3 = 13 05 A0 00. Required: mem_a = 0,1,2,3 on cycles 0–3; is_o=32'h00A00513, pc_o=0, ppc_o=4 at cycle 5; mem_a=4 at cycle 5.
2. Assert mem_busy for cycles 1–2 of a fetch. Required: byte 0 still captured; mem_req=0 on cycles 1–2; byte-1 address issued at cycle 3; word presented at cycle 7.
3. Complete word, then hold stall_i=1 for 10 cycles. Required: is_o/pc_o constant; the next word assembles, then mem_req stays 0 (full). After stall_i drops, the next word loads the following cycle with pc_o=pc+4.
4. br_e=1, br_addr=32'h1000 while icnt=2 and is_o non-zero with stall_i=1. Required: is_o=0 the next cycle; mem_a=32'h1000 the next cycle; the in-flight byte is discarded; word at 0x1000 presented 5 cycles later.
5. rst asserted at icnt=3. Required: all outputs 0 the next cycle; fetch restarts at RST_PC.
6. fpc=32'hFFFFFFFC. Required: mem_a = FFFFFFFC..FFFFFFFF; ppc_o=0; next fetch at address 0.
